// File: rtl/sha1_wb_host_if.sv
// Wishbone bus bundle between the SHA-1 host initiator and the sha1_wb responder.
interface sha1_wb_host_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/sha1_wb_host.sv
// Wishbone initiator that sequences one full SHA-1 block run on the sha1_wb responder:
// program OPS, stream 16 message words, poll for DONE, read back the digest, switch off.
module sha1_wb_host #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned MAX_POLLS    = 1023
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 start_i,
    input  logic [511:0]         block_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [1:0]           err_code_o,
    output logic [159:0]         digest_o,
    sha1_wb_host_if.master       wbm
);

    localparam logic [31:0] OPS_ADR = BASE_ADDRESS + 32'h8;
    localparam logic [31:0] MSG_ADR = BASE_ADDRESS + 32'hC;
    localparam logic [31:0] DIG_ADR = BASE_ADDRESS + 32'h10;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_HOLD, S_MSG, S_POLL, S_WAIT, S_DIG, S_OFF, S_FIN
    } state_t;

    state_t         state;
    logic [511:0]   blk;
    logic [159:0]   dig_tmp;
    logic [3:0]     word_idx;
    logic [15:0]    poll_cnt;
    logic [15:0]    to_cnt;
    logic [7:0]     gap_cnt;

    logic           bus_state;
    logic [31:0]    op_adr;
    logic           op_we;
    logic [31:0]    op_dat;
    logic [1:0]     abort_code;

    // The message register shifts left after every accepted write, so the next word is always on top.
    always_comb begin
        op_adr = OPS_ADR;
        op_we  = 1'b0;
        op_dat = 32'h0;
        case (state)
            S_CLR:  begin op_we = 1'b1; op_dat = 32'h3; end
            S_HOLD: begin op_we = 1'b1; op_dat = 32'h2; end
            S_MSG:  begin op_adr = MSG_ADR; op_we = 1'b1; op_dat = blk[511:480]; end
            S_DIG:  op_adr = DIG_ADR;
            S_OFF:  op_we = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bus_state = (state == S_CLR) || (state == S_HOLD) || (state == S_MSG) ||
                    (state == S_POLL) || (state == S_DIG) || (state == S_OFF);
    end

    // PANIC outranks DONE; the poll limit only bites on a read that did not report DONE.
    always_comb begin
        abort_code = 2'd0;
        if (bus_state && wbm.wbm_stb_o) begin
            if (wbm.wbm_ack_i) begin
                if (state == S_MSG && wbm.wbm_dat_i != 32'h1)
                    abort_code = 2'd2;
                else if (state == S_POLL && wbm.wbm_dat_i[2])
                    abort_code = 2'd3;
                else if (state == S_POLL && !wbm.wbm_dat_i[3] &&
                         32'(poll_cnt) + 32'd1 >= MAX_POLLS)
                    abort_code = 2'd3;
            end else if (32'(to_cnt) + 32'd1 >= ACK_TIMEOUT) begin
                abort_code = 2'd1;
            end
        end
    end

    // A bus state issues its access whenever stb is low, so the cycle right after an ack is the
    // single idle gap that swallows the responder's trailing ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state          <= S_IDLE;
            blk            <= '0;
            dig_tmp        <= '0;
            word_idx       <= '0;
            poll_cnt       <= '0;
            to_cnt         <= '0;
            gap_cnt        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            err_code_o     <= 2'd0;
            digest_o       <= '0;
            wbm.wbm_cyc_o  <= 1'b0;
            wbm.wbm_stb_o  <= 1'b0;
            wbm.wbm_we_o   <= 1'b0;
            wbm.wbm_sel_o  <= 4'h0;
            wbm.wbm_adr_o  <= 32'h0;
            wbm.wbm_dat_o  <= 32'h0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        blk        <= block_i;
                        busy_o     <= 1'b1;
                        error_o    <= 1'b0;
                        err_code_o <= 2'd0;
                        word_idx   <= '0;
                        poll_cnt   <= '0;
                        state      <= S_CLR;
                    end
                end
                S_WAIT: begin
                    if (32'(gap_cnt) + 32'd1 >= POLL_GAP)
                        state <= S_POLL;
                    else
                        gap_cnt <= gap_cnt + 8'd1;
                end
                S_FIN: state <= S_IDLE;
                default: begin
                    if (!wbm.wbm_stb_o) begin
                        wbm.wbm_cyc_o <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        wbm.wbm_sel_o <= 4'hF;
                        wbm.wbm_adr_o <= op_adr;
                        wbm.wbm_we_o  <= op_we;
                        wbm.wbm_dat_o <= op_dat;
                        to_cnt        <= '0;
                    end else if (abort_code != 2'd0) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_we_o  <= 1'b0;
                        wbm.wbm_sel_o <= 4'h0;
                        wbm.wbm_adr_o <= 32'h0;
                        wbm.wbm_dat_o <= 32'h0;
                        busy_o        <= 1'b0;
                        done_o        <= 1'b1;
                        error_o       <= 1'b1;
                        err_code_o    <= abort_code;
                        state         <= S_IDLE;
                    end else if (wbm.wbm_ack_i) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_we_o  <= 1'b0;
                        wbm.wbm_sel_o <= 4'h0;
                        wbm.wbm_adr_o <= 32'h0;
                        wbm.wbm_dat_o <= 32'h0;
                        case (state)
                            S_CLR:  state <= S_HOLD;
                            S_HOLD: begin
                                word_idx <= '0;
                                state    <= S_MSG;
                            end
                            S_MSG: begin
                                blk      <= {blk[479:0], 32'h0};
                                word_idx <= word_idx + 4'd1;
                                if (word_idx == 4'd15) begin
                                    poll_cnt <= '0;
                                    state    <= S_POLL;
                                end
                            end
                            S_POLL: begin
                                if (wbm.wbm_dat_i[3]) begin
                                    word_idx <= '0;
                                    state    <= S_DIG;
                                end else begin
                                    poll_cnt <= poll_cnt + 16'd1;
                                    gap_cnt  <= '0;
                                    state    <= S_WAIT;
                                end
                            end
                            // Reads arrive h4 first; shifting in from the top leaves h4 in [31:0].
                            S_DIG: begin
                                dig_tmp  <= {wbm.wbm_dat_i, dig_tmp[159:32]};
                                word_idx <= word_idx + 4'd1;
                                if (word_idx == 4'd4)
                                    state <= S_OFF;
                            end
                            S_OFF: begin
                                digest_o <= dig_tmp;
                                busy_o   <= 1'b0;
                                done_o   <= 1'b1;
                                state    <= S_FIN;
                            end
                            default: ;
                        endcase
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_wb_host.sv
// Bench for sha1_wb_host: a behavioural sha1_wb responder with fault knobs, plus a scoreboard of
// expected bus transactions and directed runs covering success, every error code and reset.
module tb_sha1_wb_host;

    localparam logic [31:0]  BASE    = 32'h30000024;
    localparam logic [31:0]  OPS_ADR = BASE + 32'h8;
    localparam logic [31:0]  MSG_ADR = BASE + 32'hC;
    localparam logic [31:0]  DIG_ADR = BASE + 32'h10;
    localparam logic [159:0] ABC_DIGEST = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [511:0] ABC_BLOCK  = {32'h61626380, {14{32'h0}}, 32'h00000018};

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_n = 1'b0;
    logic         start_i  = 1'b0;
    logic [511:0] block_i  = '0;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic [1:0]   err_code_o;
    logic [159:0] digest_o;

    sha1_wb_host_if wb ();

    sha1_wb_host dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .start_i    (start_i),
        .block_i    (block_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .err_code_o (err_code_o),
        .digest_o   (digest_o),
        .wbm        (wb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [159:0] observed,
                               input logic [159:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [159:0] sha1Block(input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {tmp[30:0], tmp[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d;
            d = c;
            c = {b[1:0], b[31:2]};
            b = a;
            a = tmp;
        end
        return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c,
                32'h10325476 + d, 32'hC3D2E1F0 + e};
    endfunction

    // Scoreboard entries are {sel, adr, we, write data or 0 for reads}.
    logic [68:0] exp_q [$];

    task automatic pushTxn(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        exp_q.push_back({4'hF, adr, we, dat});
    endtask

    task automatic pushPrefix(input logic [511:0] blk, input int nmsg);
        pushTxn(OPS_ADR, 1'b1, 32'h3);
        pushTxn(OPS_ADR, 1'b1, 32'h2);
        for (int i = 0; i < nmsg; i++) pushTxn(MSG_ADR, 1'b1, blk[511 - 32*i -: 32]);
    endtask

    task automatic pushTail(input int npolls, input bit with_dig);
        for (int i = 0; i < npolls; i++) pushTxn(OPS_ADR, 1'b0, 32'h0);
        if (with_dig) begin
            for (int i = 0; i < 5; i++) pushTxn(DIG_ADR, 1'b0, 32'h0);
            pushTxn(OPS_ADR, 1'b1, 32'h0);
        end
    endtask

    // Responder model knobs and state.
    int           mdl_hold       = 1;
    int           mdl_bad_idx    = -1;
    int           mdl_done_after = 2;
    int           mdl_txn        = 0;
    bit           mdl_never      = 1'b0;
    bit           mdl_panic      = 1'b0;
    int           mdl_msg_idx;
    int           mdl_dig_idx;
    int           mdl_polls;
    int           mdl_ack_left;
    logic [511:0] mdl_block;
    logic [159:0] mdl_digest;
    logic [31:0]  mdl_rdata;
    logic [68:0]  mdl_obs;
    logic [68:0]  mdl_exp;

    // Each access is served once; mdl_hold > 1 stretches ack so extra ack cycles hit the gap.
    always @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb.wbm_ack_i <= 1'b0;
            wb.wbm_dat_i <= 32'h0;
            mdl_ack_left  = 0;
            mdl_msg_idx   = 0;
            mdl_dig_idx   = 0;
            mdl_polls     = 0;
        end else if (mdl_ack_left > 0) begin
            mdl_ack_left--;
            wb.wbm_ack_i <= 1'b1;
        end else if (!wb.wbm_ack_i && wb.wbm_cyc_o && wb.wbm_stb_o && !mdl_never) begin
            mdl_txn++;
            mdl_obs = {wb.wbm_sel_o, wb.wbm_adr_o, wb.wbm_we_o,
                       wb.wbm_we_o ? wb.wbm_dat_o : 32'h0};
            if (exp_q.size() == 0)
                checkOutput("txn_unexpected", 160'(mdl_obs), 160'(0));
            else begin
                mdl_exp = exp_q.pop_front();
                checkOutput("txn_order", 160'(mdl_obs), 160'(mdl_exp));
            end
            mdl_rdata = 32'h0;
            if (wb.wbm_adr_o == OPS_ADR && wb.wbm_we_o) begin
                if (wb.wbm_dat_o[0]) begin
                    mdl_msg_idx = 0;
                    mdl_dig_idx = 0;
                    mdl_polls   = 0;
                end
            end else if (wb.wbm_adr_o == OPS_ADR) begin
                mdl_polls++;
                if (mdl_panic) mdl_rdata[2] = 1'b1;
                if (mdl_msg_idx == 16 && mdl_polls >= mdl_done_after) mdl_rdata[3] = 1'b1;
            end else if (wb.wbm_adr_o == MSG_ADR && wb.wbm_we_o && mdl_msg_idx < 16) begin
                mdl_block = {mdl_block[479:0], wb.wbm_dat_o};
                mdl_rdata = (mdl_msg_idx == mdl_bad_idx) ? 32'h0fffffea : 32'h1;
                mdl_msg_idx++;
                if (mdl_msg_idx == 16) mdl_digest = sha1Block(mdl_block);
            end else if (wb.wbm_adr_o == DIG_ADR && !wb.wbm_we_o && mdl_dig_idx < 5) begin
                mdl_rdata = mdl_digest[32*mdl_dig_idx +: 32];
                mdl_dig_idx++;
            end
            wb.wbm_ack_i <= 1'b1;
            wb.wbm_dat_i <= mdl_rdata;
            mdl_ack_left  = mdl_hold - 1;
        end else begin
            wb.wbm_ack_i <= 1'b0;
        end
    end

    task automatic applyStimulus(input logic [511:0] blk);
        @(negedge wb_clk_i);
        block_i = blk;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
    endtask

    // Runs until done_o plus a short tail, counting done pulses and stb-high cycles.
    task automatic runUntilDone(input int max_cycles, output int done_cnt, output int stb_cycles);
        bit seen;
        int after;
        done_cnt   = 0;
        stb_cycles = 0;
        seen       = 1'b0;
        after      = 0;
        for (int n = 0; n < max_cycles && after < 8; n++) begin
            @(negedge wb_clk_i);
            if (wb.wbm_stb_o) stb_cycles++;
            if (done_o) begin
                done_cnt++;
                seen = 1'b1;
            end
            if (seen) after++;
        end
        checkOutput("done_seen", 160'(seen), 160'(1));
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput(tag, 160'({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o,
                               wb.wbm_adr_o, wb.wbm_dat_o}), 160'(0));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dc;
        int sc;
        int txn0;
        bit found;

        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_flags", 160'({busy_o, done_o, error_o, err_code_o}), 160'(0));
        checkOutput("rst_digest", digest_o, 160'(0));
        checkIdleBus("rst_bus");
        wb_rst_n = 1'b1;
        @(negedge wb_clk_i);

        $display("[TB] abc run, single-cycle ack");
        txn0 = mdl_txn;
        pushPrefix(ABC_BLOCK, 16);
        pushTail(2, 1'b1);
        applyStimulus(ABC_BLOCK);
        checkOutput("abc_busy", 160'(busy_o), 160'(1));
        runUntilDone(2000, dc, sc);
        checkOutput("abc_digest", digest_o, ABC_DIGEST);
        checkOutput("abc_err", 160'({error_o, err_code_o}), 160'(0));
        checkOutput("abc_done_pulses", 160'(dc), 160'(1));
        checkOutput("abc_txn_count", 160'(mdl_txn - txn0), 160'(26));
        checkOutput("abc_txn_left", 160'(exp_q.size()), 160'(0));
        checkOutput("abc_busy_end", 160'(busy_o), 160'(0));
        checkIdleBus("abc_bus_idle");

        $display("[TB] responder never acks");
        mdl_never = 1'b1;
        applyStimulus(ABC_BLOCK);
        runUntilDone(1000, dc, sc);
        checkOutput("to_stb_cycles", 160'(sc), 160'(255));
        checkOutput("to_err", 160'({error_o, err_code_o}), 160'({1'b1, 2'd1}));
        checkOutput("to_done_pulses", 160'(dc), 160'(1));
        checkOutput("to_digest_kept", digest_o, ABC_DIGEST);
        checkIdleBus("to_bus_idle");
        mdl_never = 1'b0;

        $display("[TB] bad MSG_IN response on 4th write");
        mdl_bad_idx = 3;
        txn0 = mdl_txn;
        pushPrefix(ABC_BLOCK, 4);
        applyStimulus(ABC_BLOCK);
        runUntilDone(1000, dc, sc);
        repeat (20) @(negedge wb_clk_i);
        checkOutput("msg_err", 160'({error_o, err_code_o}), 160'({1'b1, 2'd2}));
        checkOutput("msg_txn_count", 160'(mdl_txn - txn0), 160'(6));
        checkOutput("msg_txn_left", 160'(exp_q.size()), 160'(0));
        mdl_bad_idx = -1;

        $display("[TB] panic on first poll");
        mdl_panic      = 1'b1;
        mdl_done_after = 1000000;
        txn0 = mdl_txn;
        pushPrefix(ABC_BLOCK, 16);
        pushTail(1, 1'b0);
        applyStimulus(ABC_BLOCK);
        runUntilDone(1000, dc, sc);
        checkOutput("panic_err", 160'({error_o, err_code_o}), 160'({1'b1, 2'd3}));
        checkOutput("panic_txn_count", 160'(mdl_txn - txn0), 160'(19));
        checkOutput("panic_txn_left", 160'(exp_q.size()), 160'(0));
        mdl_panic = 1'b0;

        $display("[TB] DONE never reported, poll limit");
        pushPrefix(ABC_BLOCK, 16);
        pushTail(1023, 1'b0);
        applyStimulus(ABC_BLOCK);
        runUntilDone(20000, dc, sc);
        checkOutput("plim_err", 160'({error_o, err_code_o}), 160'({1'b1, 2'd3}));
        checkOutput("plim_txn_left", 160'(exp_q.size()), 160'(0));
        checkOutput("plim_done_pulses", 160'(dc), 160'(1));
        mdl_done_after = 2;

        $display("[TB] abc run, ack held two cycles");
        mdl_hold = 2;
        txn0 = mdl_txn;
        pushPrefix(ABC_BLOCK, 16);
        pushTail(2, 1'b1);
        applyStimulus(ABC_BLOCK);
        runUntilDone(2000, dc, sc);
        checkOutput("hold_digest", digest_o, ABC_DIGEST);
        checkOutput("hold_err", 160'({error_o, err_code_o}), 160'(0));
        checkOutput("hold_txn_count", 160'(mdl_txn - txn0), 160'(26));
        checkOutput("hold_txn_left", 160'(exp_q.size()), 160'(0));
        mdl_hold = 1;

        $display("[TB] async reset during MSG word 7");
        pushPrefix(ABC_BLOCK, 16);
        pushTail(2, 1'b1);
        applyStimulus(ABC_BLOCK);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge wb_clk_i);
            if (mdl_msg_idx == 7 && wb.wbm_stb_o) found = 1'b1;
        end
        checkOutput("rst_reach_word7", 160'(found), 160'(1));
        checkOutput("rst_mid_stb", 160'(wb.wbm_stb_o), 160'(1));
        #1 wb_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_flags", 160'({busy_o, done_o, error_o, err_code_o}), 160'(0));
        checkOutput("rst_mid_digest", digest_o, 160'(0));
        checkIdleBus("rst_mid_bus");
        exp_q.delete();
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        @(negedge wb_clk_i);

        txn0 = mdl_txn;
        pushPrefix(ABC_BLOCK, 16);
        pushTail(2, 1'b1);
        applyStimulus(ABC_BLOCK);
        repeat (5) @(negedge wb_clk_i);
        block_i = '1;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        runUntilDone(2000, dc, sc);
        checkOutput("rerun_digest", digest_o, ABC_DIGEST);
        checkOutput("rerun_err", 160'({error_o, err_code_o}), 160'(0));
        checkOutput("rerun_done_pulses", 160'(dc), 160'(1));
        checkOutput("rerun_txn_count", 160'(mdl_txn - txn0), 160'(26));
        checkOutput("rerun_txn_left", 160'(exp_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
